// File: rtl/load_stream_front.sv
// Front end for the runtime table loader: parses a load-packet header, buffers the payload,
// then pulses start and replays one word per loader write slot. Define LOADFRONT_CKSUM_EN for the XOR trailer beat.
module load_stream_front #(
  parameter int unsigned DWIDTH     = 512,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned FIFO_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [ADDR_W-1:0] num_entry_config_table,
  output logic [ADDR_W-1:0] num_entry_inbound,
  output logic              start,
  output logic [DWIDTH-1:0] load_data,
  output logic              load_valid,
  input  logic              loader_done,
  output logic              busy,
  output logic              err
);
  localparam int unsigned TOT_W   = 2*ADDR_W + 4;
  localparam int unsigned NUM_TAB = 2*NUM_COL + 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_DRAIN, S_START, S_STREAM, S_WAIT_DONE
  } state_t;

  state_t              r_state, w_next_state;
  logic [ADDR_W-1:0]   r_c, r_i;
  logic [TOT_W-1:0]    r_total, r_cnt;
  logic [DWIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W:0]      r_wr, r_rd;
  logic                r_tready, r_busy, r_start, r_valid, r_err;
  logic [DWIDTH-1:0]   r_data;

  logic                w_acc, w_hdr, w_push, w_pop, w_flush, w_err, w_cnt_inc;
  logic                w_full, w_empty, w_hdr_bad;
  logic [ADDR_W-1:0]   w_hdr_c, w_hdr_i;
  logic [TOT_W-1:0]    w_hdr_total, w_beat_n;
`ifdef LOADFRONT_CKSUM_EN
  logic [DWIDTH-1:0]   r_xor;
`endif

  assign w_acc       = s_tvalid && r_tready;
  assign w_hdr_c     = s_tdata[ADDR_W-1:0];
  assign w_hdr_i     = s_tdata[2*ADDR_W-1:ADDR_W];
  assign w_hdr_total = TOT_W'(w_hdr_c) * TOT_W'(NUM_TAB) + TOT_W'(w_hdr_i);
  assign w_hdr_bad   = s_tlast || (w_hdr_c == '0) || (w_hdr_i == '0) ||
                       (32'(w_hdr_total) > FIFO_DEPTH);
  assign w_beat_n    = r_cnt + TOT_W'(1);
  assign w_empty     = (r_wr == r_rd);
  assign w_full      = (r_wr[PTR_W] != r_rd[PTR_W]) && (r_wr[PTR_W-1:0] == r_rd[PTR_W-1:0]);

  // Next-state and datapath strobes
  always_comb begin
    w_next_state = r_state;
    w_hdr        = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_flush      = 1'b0;
    w_err        = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_hdr   = 1'b1;
          w_flush = 1'b1;
          if (w_hdr_bad) begin
            w_err        = 1'b1;
            w_next_state = s_tlast ? S_IDLE : S_DRAIN;
          end else begin
            w_next_state = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (w_acc) begin
          w_cnt_inc = 1'b1;
          if (w_beat_n <= r_total) begin
            w_push = 1'b1;
            if (s_tlast) begin
`ifdef LOADFRONT_CKSUM_EN
              w_err        = 1'b1;
              w_flush      = 1'b1;
              w_next_state = S_IDLE;
`else
              if (w_beat_n == r_total) begin
                w_next_state = S_START;
              end else begin
                w_err        = 1'b1;
                w_flush      = 1'b1;
                w_next_state = S_IDLE;
              end
`endif
            end
          end else begin
`ifdef LOADFRONT_CKSUM_EN
            if (s_tlast && (s_tdata == r_xor)) begin
              w_next_state = S_START;
            end else begin
              w_err        = 1'b1;
              w_flush      = 1'b1;
              w_next_state = s_tlast ? S_IDLE : S_DRAIN;
            end
`else
            w_err        = 1'b1;
            w_flush      = 1'b1;
            w_next_state = s_tlast ? S_IDLE : S_DRAIN;
`endif
          end
        end
      end
      S_DRAIN: begin
        if (w_acc && s_tlast) w_next_state = S_IDLE;
      end
      S_START: begin
        w_pop        = 1'b1;
        w_next_state = S_STREAM;
      end
      S_STREAM: begin
        if (r_cnt == r_total) begin
          w_next_state = S_WAIT_DONE;
        end else begin
          w_pop     = 1'b1;
          w_cnt_inc = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (loader_done) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, registered outputs, header fields and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tready <= 1'b0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_c     <= '0;
      r_i     <= '0;
      r_total <= '0;
      r_cnt   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
    end else begin
      r_state  <= w_next_state;
      r_tready <= (w_next_state == S_IDLE) || (w_next_state == S_RECV) ||
                  (w_next_state == S_DRAIN);
      r_busy   <= (w_next_state != S_IDLE);
      r_start  <= (w_next_state == S_START);
      r_valid  <= (w_next_state == S_STREAM);
      r_err    <= w_err;
      if (w_hdr) begin
        r_c     <= w_hdr_c;
        r_i     <= w_hdr_i;
        r_total <= w_hdr_total;
      end
      // r_cnt counts received beats in RECV, then words handed out from START on
      if (w_hdr) r_cnt <= '0;
      else if (r_state == S_START) r_cnt <= TOT_W'(1);
      else if (w_cnt_inc) r_cnt <= w_beat_n;
      if (w_flush) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + (PTR_W+1)'(1);
        if (w_pop) begin
          r_rd   <= r_rd + (PTR_W+1)'(1);
          r_data <= r_mem[r_rd[PTR_W-1:0]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[PTR_W-1:0]] <= s_tdata;
  end

`ifdef LOADFRONT_CKSUM_EN
  // Running XOR of the payload words stored for this packet
  always_ff @(posedge clk) begin
    if (rst || w_hdr) r_xor <= '0;
    else if (w_push) r_xor <= r_xor ^ s_tdata;
  end
`endif

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(w_push && !w_flush && w_full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(w_pop && w_empty));

  assign s_tready               = r_tready;
  assign busy                   = r_busy;
  assign start                  = r_start;
  assign load_valid             = r_valid;
  assign load_data              = r_data;
  assign err                    = r_err;
  assign num_entry_config_table = r_c;
  assign num_entry_inbound      = r_i;
endmodule

// File: doc/load_stream_front.md
Name: load_stream_front

Overview:
- Upstream front end for the runtime table loader.
- Accepts one load packet at a time from an AXI-stream-style input and parses its header into the config-table and inbound entry counts.
- Buffers the full payload, then pulses start and replays the payload one word per cycle, aligned with the loader's write slots: config/state tables first, then inbound data.
- Holds the entry counts stable until the loader reports done.

Parameters:
- DWIDTH, 512, payload word width.
- ADDR_W, 8, entry-count / register-file address width; equals loader address width.
- NUM_COL, 4, column count; loader writes 2*NUM_COL+1 tables.
- FIFO_DEPTH, 1024, payload buffer depth in words; power of two.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_tdata  in  DWIDTH  stream data
- s_tvalid  in  1  stream valid
- s_tlast  in  1  last beat of packet
- s_tready  out  1  stream ready
- num_entry_config_table  out  ADDR_W  entries per config/state table, to loader
- num_entry_inbound  out  ADDR_W  inbound entries, to loader
- start  out  1  one-cycle start pulse to loader
- load_data  out  DWIDTH  payload word for the current loader write slot
- load_valid  out  1  load_data valid
- loader_done  in  1  loader done pulse
- busy  out  1  high whenever the FSM is not in IDLE
- err  out  1  one-cycle pulse on packet rejection

Behaviour:
- Reset: all outputs 0; FIFO emptied; FSM to IDLE. Reset mid-operation aborts everything, and the partial packet is not recovered.
- Beat accepted when s_tvalid && s_tready.
- Header beat (first beat of a packet):
  - C = s_tdata[ADDR_W-1:0]
  - I = s_tdata[2*ADDR_W-1:ADDR_W]
  - TOTAL = C*(2*NUM_COL+1) + I, computed in 2*ADDR_W+4 bits, no truncation.
- FSM states:
  - IDLE: s_tready=1. On header accept, register C, I, TOTAL.
    - Header with tlast=1, C==0, I==0, or TOTAL>FIFO_DEPTH → err pulse. Go to DRAIN, or stay in IDLE if tlast=1.
    - Otherwise → RECV.
  - RECV: s_tready=1. Each beat is pushed to the FIFO and the count is incremented.
    - tlast with count==TOTAL → START.
    - tlast with count<TOTAL → err, flush FIFO, IDLE.
    - Beat count exceeding TOTAL → err, flush, DRAIN.
  - DRAIN: s_tready=1. Beats are discarded; on tlast → IDLE.
  - START: s_tready=0. start=1 for exactly this cycle. The FIFO head is prefetched so the first word is on load_data next cycle.
    - → STREAM
  - STREAM: s_tready=0. load_valid=1 and one FIFO pop per cycle, for exactly TOTAL consecutive cycles, at start cycle+1 through start cycle+TOTAL. This matches the loader's write slots with no gaps.
    - → WAIT_DONE
  - WAIT_DONE: s_tready=0; load_valid=0.
    - On loader_done → IDLE.
- num_entry_config_table and num_entry_inbound are driven from registered C and I. They are stable from START through WAIT_DONE and hold their last value in IDLE.
- loader_done outside WAIT_DONE is ignored.
- Only one packet is in flight; back-to-back packets are accepted from the cycle after the return to IDLE.
- The FIFO never overflows because TOTAL ≤ FIFO_DEPTH is checked at the header. An internal overflow or underflow is an assertion failure.
- TOTAL==FIFO_DEPTH is legal.

Optional Feature:
- Macro LOADFRONT_CKSUM_EN.
- When defined:
  - Each packet carries one extra trailing beat after the TOTAL payload words. This beat holds the running XOR of all payload words and carries tlast.
  - RECV expects tlast on beat TOTAL+1.
  - Checksum mismatch → err pulse, FIFO flushed, no start, return to IDLE.
  - The checksum beat is never written to the FIFO.
- When undefined:
  - No checksum beat; tlast falls on payload beat TOTAL.

Test Plan:
- NUM_COL=2, header C=3, I=4, 19 payload words 0..18 with tlast on the last → start pulses once, then load_valid is high for 19 cycles with load_data = 0..18 in order. Counts read 3/4 until loader_done, and s_tready is 0 until then.
- Header C=0, I=5 → err pulse; beats are drained until tlast; start never asserts; the next valid packet is processed normally.
- FIFO_DEPTH=16, NUM_COL=2, C=3, I=2 (TOTAL=17) → err, drain. With I=1 (TOTAL=16) the packet is accepted and 16 words are streamed.
- C=1, I=1, tlast on payload beat 4 of 6 → err, FIFO flushed, no start. Extra beat 7 without tlast → err, then DRAIN until tlast.
- Reset asserted during STREAM (word 5 of 19) → load_valid=0 and busy=0 the next cycle. A fresh packet after reset streams from word 0.
- With LOADFRONT_CKSUM_EN defined: correct XOR trailer → normal stream; trailer bit-flipped → err, no start.
